// File: rtl/alu_exec_ctrl.sv
// Control sequencer for register-immediate and register-register ADD/SUB.
// Latches one instruction per start and walks the datapath through fetch, operands, execute and write-back.
module alu_exec_ctrl #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 5,
    parameter int SIGN_EXT = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [15:0]         i_instr,
    output logic                o_busy,
    output logic                o_pc_inc,
    output logic [NUM_REGS-1:0] o_reg_out_en,
    output logic [NUM_REGS-1:0] o_reg_in_en,
    output logic                o_alu_in1,
    output logic                o_alu_in2,
    output logic                o_alu_outlatch,
    output logic                o_alu_out_en,
    output logic                o_imm_out_en,
    output logic [DATA_W-1:0]   o_imm_data,
    output logic [1:0]          o_alu_op,
    output logic                o_done,
    output logic                o_illegal
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_SRC1  = 4'd2,
        S_SRC2  = 4'd3,
        S_EXEC  = 4'd4,
        S_DRIVE = 4'd5,
        S_WB    = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;
    logic [15:0]         r_ir;

    logic [3:0]          w_op;
    logic [5:0]          w_p1;
    logic [5:0]          w_p2;
    logic                w_is_imm;
    logic                w_is_reg;
    logic                w_legal;
    logic [1:0]          w_op_sel;
    logic [DATA_W-1:0]   w_imm_ext;

    logic                w_busy;
    logic                w_pc_inc;
    logic [NUM_REGS-1:0] w_reg_out_en;
    logic [NUM_REGS-1:0] w_reg_in_en;
    logic                w_alu_in1;
    logic                w_alu_in2;
    logic                w_alu_outlatch;
    logic                w_alu_out_en;
    logic                w_imm_out_en;
    logic [DATA_W-1:0]   w_imm_data;
    logic [1:0]          w_alu_op;
    logic                w_done;
    logic                w_illegal;

    function automatic logic [NUM_REGS-1:0] f_onehot(input logic [5:0] idx);
        logic [NUM_REGS-1:0] v;
        v = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (idx == 6'(i));
        end
        return v;
    endfunction

    assign w_op      = r_ir[15:12];
    assign w_p1      = r_ir[11:6];
    assign w_p2      = r_ir[5:0];
    assign w_is_imm  = (w_op == 4'h1) || (w_op == 4'h2);
    assign w_is_reg  = (w_op == 4'h3) || (w_op == 4'h4);
    assign w_legal   = ({1'b0, w_p1} < 7'(NUM_REGS)) &&
                       (w_is_imm || (w_is_reg && ({1'b0, w_p2} < 7'(NUM_REGS))));
    assign w_op_sel  = ((w_op == 4'h2) || (w_op == 4'h4)) ? 2'b01 : 2'b00;
    assign w_imm_ext = (SIGN_EXT != 0) ? {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]}
                                       : {{(DATA_W-6){1'b0}}, r_ir[5:0]};

    // Next-state sequencing; unused encodings fall back to IDLE.
    always_comb begin
        w_nxt_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_nxt_state = i_start ? S_FETCH : S_IDLE;
            S_FETCH: w_nxt_state = w_legal ? S_SRC1 : S_ERR;
            S_SRC1:  w_nxt_state = S_SRC2;
            S_SRC2:  w_nxt_state = S_EXEC;
            S_EXEC:  w_nxt_state = S_DRIVE;
            S_DRIVE: w_nxt_state = S_WB;
            S_WB:    w_nxt_state = S_DONE;
            S_DONE:  w_nxt_state = S_IDLE;
            S_ERR:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded for the upcoming state so the registered copies line up with it.
    always_comb begin
        w_busy         = (w_nxt_state != S_IDLE);
        w_pc_inc       = 1'b0;
        w_reg_out_en   = {NUM_REGS{1'b0}};
        w_reg_in_en    = {NUM_REGS{1'b0}};
        w_alu_in1      = 1'b0;
        w_alu_in2      = 1'b0;
        w_alu_outlatch = 1'b0;
        w_alu_out_en   = 1'b0;
        w_imm_out_en   = 1'b0;
        w_imm_data     = {DATA_W{1'b0}};
        w_alu_op       = 2'b00;
        w_done         = 1'b0;
        w_illegal      = 1'b0;
        case (w_nxt_state)
            S_FETCH: w_pc_inc = 1'b1;
            S_SRC1: begin
                w_reg_out_en = f_onehot(w_p1);
                w_alu_in1    = 1'b1;
                w_alu_op     = w_op_sel;
            end
            S_SRC2: begin
                if (w_is_imm) begin
                    w_imm_out_en = 1'b1;
                    w_imm_data   = w_imm_ext;
                end else begin
                    w_reg_out_en = f_onehot(w_p2);
                end
                w_alu_in2 = 1'b1;
                w_alu_op  = w_op_sel;
            end
            S_EXEC: begin
                w_alu_outlatch = 1'b1;
                w_alu_op       = w_op_sel;
            end
            S_DRIVE: begin
                w_alu_out_en = 1'b1;
                w_alu_op     = w_op_sel;
            end
            S_WB: begin
                w_alu_out_en = 1'b1;
                w_reg_in_en  = f_onehot(w_p1);
                w_alu_op     = w_op_sel;
            end
            S_DONE:  w_done    = 1'b1;
            S_ERR:   w_illegal = 1'b1;
            default: w_busy    = 1'b0;
        endcase
    end

    // State and instruction register; the instruction is captured only on acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_nxt_state;
            if ((r_state == S_IDLE) && i_start) begin
                r_ir <= i_instr;
            end
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy         <= 1'b0;
            o_pc_inc       <= 1'b0;
            o_reg_out_en   <= {NUM_REGS{1'b0}};
            o_reg_in_en    <= {NUM_REGS{1'b0}};
            o_alu_in1      <= 1'b0;
            o_alu_in2      <= 1'b0;
            o_alu_outlatch <= 1'b0;
            o_alu_out_en   <= 1'b0;
            o_imm_out_en   <= 1'b0;
            o_imm_data     <= {DATA_W{1'b0}};
            o_alu_op       <= 2'b00;
            o_done         <= 1'b0;
            o_illegal      <= 1'b0;
        end else begin
            o_busy         <= w_busy;
            o_pc_inc       <= w_pc_inc;
            o_reg_out_en   <= w_reg_out_en;
            o_reg_in_en    <= w_reg_in_en;
            o_alu_in1      <= w_alu_in1;
            o_alu_in2      <= w_alu_in2;
            o_alu_outlatch <= w_alu_outlatch;
            o_alu_out_en   <= w_alu_out_en;
            o_imm_out_en   <= w_imm_out_en;
            o_imm_data     <= w_imm_data;
            o_alu_op       <= w_alu_op;
            o_done         <= w_done;
            o_illegal      <= w_illegal;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: zero- and sign-extending instances share one stimulus stream.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;

    logic        busy, pc_inc, alu_in1, alu_in2, alu_outlatch, alu_out_en, imm_out_en, done, illegal;
    logic [4:0]  reg_out_en, reg_in_en;
    logic [15:0] imm_data;
    logic [1:0]  alu_op;

    logic        sx_busy, sx_pc_inc, sx_alu_in1, sx_alu_in2, sx_alu_outlatch, sx_alu_out_en, sx_imm_out_en, sx_done, sx_illegal;
    logic [4:0]  sx_reg_out_en, sx_reg_in_en;
    logic [15:0] sx_imm_data;
    logic [1:0]  sx_alu_op;

    int n_chk;
    int n_fail;

    alu_exec_ctrl #(.DATA_W(16), .NUM_REGS(5), .SIGN_EXT(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_instr(instr),
        .o_busy(busy), .o_pc_inc(pc_inc), .o_reg_out_en(reg_out_en), .o_reg_in_en(reg_in_en),
        .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_outlatch(alu_outlatch),
        .o_alu_out_en(alu_out_en), .o_imm_out_en(imm_out_en), .o_imm_data(imm_data),
        .o_alu_op(alu_op), .o_done(done), .o_illegal(illegal)
    );

    alu_exec_ctrl #(.DATA_W(16), .NUM_REGS(5), .SIGN_EXT(1)) dut_sx (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_instr(instr),
        .o_busy(sx_busy), .o_pc_inc(sx_pc_inc), .o_reg_out_en(sx_reg_out_en), .o_reg_in_en(sx_reg_in_en),
        .o_alu_in1(sx_alu_in1), .o_alu_in2(sx_alu_in2), .o_alu_outlatch(sx_alu_outlatch),
        .o_alu_out_en(sx_alu_out_en), .o_imm_out_en(sx_imm_out_en), .o_imm_data(sx_imm_data),
        .o_alu_op(sx_alu_op), .o_done(sx_done), .o_illegal(sx_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_out();
        return 64'({busy, pc_inc, reg_out_en, reg_in_en, alu_in1, alu_in2, alu_outlatch,
                    alu_out_en, imm_out_en, imm_data, alu_op, done, illegal});
    endfunction

    function automatic logic [63:0] all_out_sx();
        return 64'({sx_busy, sx_pc_inc, sx_reg_out_en, sx_reg_in_en, sx_alu_in1, sx_alu_in2, sx_alu_outlatch,
                    sx_alu_out_en, sx_imm_out_en, sx_imm_data, sx_alu_op, sx_done, sx_illegal});
    endfunction

    // Bus exclusivity and one-hot enables, checked mid-cycle on both instances.
    always @(negedge clk) begin
        check_eq("bus_excl", 64'(($countones(reg_out_en) + 32'(imm_out_en) + 32'(alu_out_en)) <= 1), 64'd1);
        check_eq("bus_excl_sx", 64'(($countones(sx_reg_out_en) + 32'(sx_imm_out_en) + 32'(sx_alu_out_en)) <= 1), 64'd1);
        check_eq("in_onehot", 64'($countones(reg_in_en) <= 1), 64'd1);
    end

    task automatic exec_legal(input string nm, input logic [15:0] ins, input logic [4:0] e_src1,
                              input logic [4:0] e_src2, input logic [4:0] e_wb, input logic e_imm_en,
                              input logic [15:0] e_imm0, input logic [15:0] e_imm1, input logic [1:0] e_op);
        start = 1'b1;
        instr = ins;
        tick();
        start = 1'b0;
        instr = 16'hFFFF;
        check_eq({nm, "_c1_pc"},   64'({busy, pc_inc, reg_out_en}), 64'({1'b1, 1'b1, 5'b00000}));
        tick();
        check_eq({nm, "_c2_src1"}, 64'({pc_inc, reg_out_en, alu_in1, alu_in2}), 64'({1'b0, e_src1, 1'b1, 1'b0}));
        check_eq({nm, "_c2_op"},   64'({alu_op, sx_alu_op}), 64'({e_op, e_op}));
        tick();
        check_eq({nm, "_c3_src2"}, 64'({reg_out_en, imm_out_en, alu_in1, alu_in2}), 64'({e_src2, e_imm_en, 1'b0, 1'b1}));
        check_eq({nm, "_c3_imm"},  64'({imm_data, sx_imm_data, alu_op}), 64'({e_imm0, e_imm1, e_op}));
        tick();
        check_eq({nm, "_c4_exec"}, 64'({alu_outlatch, alu_out_en, alu_op}), 64'({1'b1, 1'b0, e_op}));
        tick();
        check_eq({nm, "_c5_drv"},  64'({alu_outlatch, alu_out_en, reg_in_en, alu_op}), 64'({1'b0, 1'b1, 5'b00000, e_op}));
        tick();
        check_eq({nm, "_c6_wb"},   64'({alu_out_en, reg_in_en, alu_op, done}), 64'({1'b1, e_wb, e_op, 1'b0}));
        tick();
        check_eq({nm, "_c7_done"}, 64'({busy, done, reg_in_en, alu_op}), 64'({1'b1, 1'b1, 5'b00000, 2'b00}));
        tick();
        check_eq({nm, "_c8_idle"}, all_out(), 64'd0);
    endtask

    task automatic exec_illegal(input string nm, input logic [15:0] ins);
        start = 1'b1;
        instr = ins;
        tick();
        start = 1'b0;
        check_eq({nm, "_c1"}, 64'({busy, pc_inc, illegal, reg_out_en, reg_in_en}), 64'({1'b1, 1'b1, 1'b0, 5'b0, 5'b0}));
        tick();
        check_eq({nm, "_c2"}, 64'({busy, pc_inc, illegal, reg_out_en, reg_in_en, alu_in1}), 64'({1'b1, 1'b0, 1'b1, 5'b0, 5'b0, 1'b0}));
        tick();
        check_eq({nm, "_c3"}, all_out(), 64'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        instr  = 16'h0000;
        #12;
        check_eq("reset_zero", all_out(), 64'd0);
        check_eq("reset_zero_sx", all_out_sx(), 64'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_after_rst", all_out(), 64'd0);

        exec_legal("addi", 16'h1083, 5'b00100, 5'b00000, 5'b00100, 1'b1, 16'h0003, 16'h0003, 2'b00);
        exec_legal("subi", 16'h20BF, 5'b00100, 5'b00000, 5'b00100, 1'b1, 16'h003F, 16'hFFFF, 2'b01);
        exec_legal("add",  16'h3042, 5'b00010, 5'b00100, 5'b00010, 1'b0, 16'h0000, 16'h0000, 2'b00);
        exec_legal("sub",  16'h4042, 5'b00010, 5'b00100, 5'b00010, 1'b0, 16'h0000, 16'h0000, 2'b01);
        exec_legal("addi_r4", 16'h1101, 5'b10000, 5'b00000, 5'b10000, 1'b1, 16'h0001, 16'h0001, 2'b00);

        exec_illegal("ill_p1", 16'h11C0);
        exec_illegal("ill_op", 16'h5000);
        exec_illegal("ill_p2", 16'h3045);

        // start held high while instr toggles; acceptance always lands on an even cycle (0x1083).
        for (int k = 0; k < 24; k++) begin
            start = 1'b1;
            instr = (k % 2 == 1) ? 16'h3042 : 16'h1083;
            tick();
            check_eq("b2b_pc",   64'(pc_inc),     64'((k + 1) % 8 == 1));
            check_eq("b2b_done", 64'(done),       64'((k + 1) % 8 == 7));
            check_eq("b2b_rout", 64'(reg_out_en), ((k + 1) % 8 == 2) ? 64'd4 : 64'd0);
            check_eq("b2b_rin",  64'(reg_in_en),  ((k + 1) % 8 == 6) ? 64'd4 : 64'd0);
            check_eq("b2b_busy", 64'(busy),       64'((k + 1) % 8 != 0));
        end
        start = 1'b0;
        tick();

        // Back-to-back illegal: one instruction every 3 cycles.
        for (int k = 0; k < 6; k++) begin
            start = 1'b1;
            instr = 16'h5000;
            tick();
            check_eq("b2b_ill_pc",  64'(pc_inc),  64'((k + 1) % 3 == 1));
            check_eq("b2b_ill_ill", 64'(illegal), 64'((k + 1) % 3 == 2));
            check_eq("b2b_ill_rin", 64'(reg_in_en), 64'd0);
        end
        start = 1'b0;
        tick();
        check_eq("b2b_ill_end", all_out(), 64'd0);

        // Reset asserted during EXEC.
        start = 1'b1;
        instr = 16'h1083;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("rst_pre_exec", 64'(alu_outlatch), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_zero", all_out(), 64'd0);
        check_eq("rst_async_zero_sx", all_out_sx(), 64'd0);
        tick();
        tick();
        check_eq("rst_hold_zero", all_out(), 64'd0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("rst_no_resume", 64'({busy, done, reg_in_en}), 64'd0);
        end
        exec_legal("addi_post_rst", 16'h1083, 5'b00100, 5'b00000, 5'b00100, 1'b1, 16'h0003, 16'h0003, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Parametrised control sequencer for register-immediate and register-register ALU instructions; the next generation of the ALU-immediate control FSM. It sits between the instruction register and the shared datapath bus. On a `start` pulse it captures one 16-bit instruction and drives one-hot register output/input enables, ALU operand/result latch strobes, an extended immediate onto the bus, and a `pc_inc` pulse. It ends with a `done` or `illegal` pulse. Unlike its predecessor, it latches the instruction, has a start/busy handshake, supports reg-reg forms, has configurable register count, immediate width and extension, and rejects illegal encodings.

## Interface
- `DATA_W`, 16: bus and immediate output width; must be ≥ 8.
- `NUM_REGS`, 5: number of addressable registers; 1..64.
- `SIGN_EXT`, 0: 0 = zero-extend the 6-bit immediate, 1 = sign-extend it.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to execute `instr`; sampled only in IDLE.
- `instr` in 16: opcode [15:12], p1 [11:6] (destination and first source), p2 [5:0] (immediate or second source register).
- `busy` out 1: high in every state except IDLE.
- `pc_inc` out 1: program-counter increment strobe.
- `reg_out_en` out NUM_REGS: one-hot register-to-bus enable.
- `reg_in_en` out NUM_REGS: one-hot bus-to-register load enable.
- `alu_in1` out 1: ALU operand-1 latch strobe.
- `alu_in2` out 1: ALU operand-2 latch strobe.
- `alu_outlatch` out 1: ALU result latch strobe.
- `alu_out_en` out 1: ALU-result-to-bus enable.
- `imm_out_en` out 1: immediate-to-bus enable.
- `imm_data` out DATA_W: extended immediate.
- `alu_op` out 2: operation select; 00 = ADD, 01 = SUB.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: one-cycle rejection pulse.

## Operation
- **Opcodes:**
  - 4'h1 ADDI and 4'h2 SUBI are immediate forms.
  - 4'h3 ADD and 4'h4 SUB are register forms.
  - All other opcodes are illegal.
- **Capture:** in IDLE with `start`=1, `instr` is registered into `ir`. Every later output decodes from `ir` only, so changes on `instr` while busy have no effect. `start` is ignored when not in IDLE.
- **Register select:** index i selects bit i of `reg_out_en` / `reg_in_en`.
- **Illegal encodings:** an illegal opcode, p1 ≥ NUM_REGS, or (register form only) p2 ≥ NUM_REGS.
- **`imm_data`:** `ir[5:0]` extended to DATA_W per SIGN_EXT. It is 0 whenever `imm_out_en`=0.
- **`alu_op`:** 00 for opcodes 1 and 3, 01 for opcodes 2 and 4. It is held from SRC1 through WB and is 00 elsewhere.
- **States** (Moore; outputs decoded from the state register and `ir`):
  - **IDLE:** all outputs 0. Goes to FETCH on `start`.
  - **FETCH:** `pc_inc`=1. Goes to ERR if the encoding is illegal, else to SRC1.
  - **SRC1:** `reg_out_en[p1]`=1, `alu_in1`=1. Goes to SRC2.
  - **SRC2:**
    - Immediate form: `imm_out_en`=1, `alu_in2`=1.
    - Register form: `reg_out_en[p2]`=1, `alu_in2`=1.
    - Goes to EXEC.
  - **EXEC:** `alu_outlatch`=1. Goes to DRIVE.
  - **DRIVE:** `alu_out_en`=1. Goes to WB.
  - **WB:** `alu_out_en`=1, `reg_in_en[p1]`=1. Goes to DONE.
  - **DONE:** `done`=1. Goes to IDLE.
  - **ERR:** `illegal`=1, no register write. Goes to IDLE.
- **Bus exclusivity:** at most one of {any `reg_out_en` bit, `imm_out_en`, `alu_out_en`} is high in any cycle. `reg_out_en` and `reg_in_en` are each zero or one-hot.
- **Unused state encodings:** any unused encoding returns to IDLE on the next edge with all outputs 0.

## Timing
- **Reset:** `rst_n`=0 forces IDLE immediately, asynchronously. Every output is 0, including `imm_data` and `alu_op`; `ir` is cleared.
  - Reset mid-instruction aborts it with no `done`, no `illegal` and no further `reg_in_en`.
  - Operation resumes on the first rising edge after `rst_n` goes high.
- **Legal instruction, cycle by cycle** (cycle 0 = the cycle `start` is seen high in IDLE):
  - 1: FETCH
  - 2: SRC1
  - 3: SRC2
  - 4: EXEC
  - 5: DRIVE
  - 6: WB
  - 7: DONE
  - 8: IDLE; a new `start` is accepted here.
  - Throughput: one instruction per 8 cycles.
- **Illegal instruction:** 1 FETCH, 2 ERR, 3 IDLE.
- **`pc_inc`:** exactly one pulse per accepted instruction, legal or illegal.
- **`busy`:** high from cycle 1 until the cycle before IDLE is re-entered.
- **Back-to-back:** `start` held high continuously yields an instruction accepted every 8 cycles (legal) or 3 cycles (illegal), with no lost or duplicated pulses.

## Test plan
- **ADDI:** DATA_W=16, NUM_REGS=5, SIGN_EXT=0; `instr`=0x1083 with `start` pulsed.
  - Cycle 1: `pc_inc`.
  - Cycle 2: `reg_out_en`=5'b00100.
  - Cycle 3: `imm_out_en`=1, `imm_data`=0x0003.
  - Cycle 6: `reg_in_en`=5'b00100, `alu_op`=00.
  - Cycle 7: `done`.
- **SUBI sign extension:** `instr`=0x20BF.
  - SIGN_EXT=1: `imm_data`=0xFFFF in SRC2.
  - SIGN_EXT=0: `imm_data`=0x003F in SRC2.
  - Both: `alu_op`=01 in SRC1–WB.
- **Register ADD:** `instr`=0x3042.
  - SRC1: `reg_out_en`=5'b00010.
  - SRC2: `reg_out_en`=5'b00100, `imm_out_en`=0.
  - WB: `reg_in_en`=5'b00010.
  - Bus-exclusivity assertion checked every cycle.
- **Illegal encodings:** `instr`=0x11C0 (p1=7 ≥ 5), then 0x5000, then 0x3045 (p2=5).
  - Each: `pc_inc` at cycle 1, `illegal` at cycle 2, `reg_in_en` never set, IDLE at cycle 3.
- **Handshake:** `start` held high with `instr` toggling between 0x1083 and 0x3042 every cycle.
  - Each instruction completes per the `instr` value sampled at its acceptance cycle.
  - `done` pulses every 8 cycles.
- **Reset mid-op:** drop `rst_n` in EXEC.
  - All outputs 0 immediately.
  - No `done` or `reg_in_en` follows.
  - A fresh 0x1083 after release completes normally.
